// File: rtl/mux_pipe_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_pipe_stage_if
// Purpose  : Handshake/data bundle between upstream, mux_pipe_stage, downstream.
// Revision : 1.0
// ============================================================================
interface mux_pipe_stage_if #(
   parameter int WIDTH  = 64,
   parameter int NUM_IN = 4
);
   localparam int SEL_W = $clog2(NUM_IN);

   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]        in_sel;
   logic                    in_valid;
   logic                    in_ready;
   logic                    flush;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_idx;
   logic                    out_sel_err;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output in_data, in_sel, in_valid, flush, out_ready,
      input  in_ready, out_data, out_idx, out_sel_err, out_valid
   );

   modport slave (
      input  in_data, in_sel, in_valid, flush, out_ready,
      output in_ready, out_data, out_idx, out_sel_err, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/mux_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : mux_pipe_stage
// Purpose  : Registered N:1 operand mux with valid/ready and a two-entry skid.
// Revision : 1.0
// ============================================================================
module mux_pipe_stage #(
   parameter int WIDTH  = 64,
   parameter int NUM_IN = 4
) (
   input  wire logic         clk,
   input  wire logic         reset,
   mux_pipe_stage_if.slave   bus
);
   localparam int SEL_W = $clog2(NUM_IN);
   localparam logic [SEL_W:0] c_NUM_IN = (SEL_W+1)'(NUM_IN);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] idx;
      logic             err;
   } beat_t;

   beat_t r_main;
   beat_t r_skid;
   logic  r_main_valid;
   logic  r_skid_valid;

   beat_t w_beat;
   logic  w_sel_ok;
   logic  w_accept;
   logic  w_emit;

   // Out-of-range selects yield a zero word but keep the raw index for debug.
   always_comb begin
      w_sel_ok    = ({1'b0, bus.in_sel} < c_NUM_IN);
      w_beat.data = '0;
      w_beat.idx  = bus.in_sel;
      w_beat.err  = !w_sel_ok;
      for (int k = 0; k < NUM_IN; k++) begin
         if (bus.in_sel == SEL_W'(k)) begin
            w_beat.data = bus.in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign w_accept = bus.in_valid && !r_skid_valid && !bus.flush;
   assign w_emit   = r_main_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_main       <= '0;
         r_skid       <= '0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (bus.flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (!r_main_valid || w_emit) begin
         if (r_skid_valid) begin
            r_main       <= r_skid;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
         end else if (w_accept) begin
            r_main       <= w_beat;
            r_main_valid <= 1'b1;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_skid       <= w_beat;
         r_skid_valid <= 1'b1;
      end
   end

   assign bus.in_ready    = !r_skid_valid;
   assign bus.out_data    = r_main.data;
   assign bus.out_idx     = r_main.idx;
   assign bus.out_sel_err = r_main.err;
   assign bus.out_valid   = r_main_valid;
endmodule
`default_nettype wire

// File: tb/tb_mux_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_pipe_stage
// Purpose  : Directed table-driven bench for mux_pipe_stage (NUM_IN=4 and 3).
// Revision : 1.0
// ============================================================================
module tb_mux_pipe_stage;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mux_pipe_stage_if #(.WIDTH(64), .NUM_IN(4)) bus4 ();
   mux_pipe_stage_if #(.WIDTH(64), .NUM_IN(3)) bus3 ();

   mux_pipe_stage #(.WIDTH(64), .NUM_IN(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
   mux_pipe_stage #(.WIDTH(64), .NUM_IN(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

   typedef struct {
      logic        v;
      logic [1:0]  s;
      logic        r;
      logic        f;
      logic        ev;
      logic [63:0] ed;
      logic [1:0]  ei;
      logic        ee;
      logic        eir;
   } vec_t;

   vec_t tbl[20];

   function automatic logic [63:0] dword(int k);
      logic [3:0] n;
      n = k[3:0];
      return {16{n}};
   endfunction

   function automatic vec_t mk(logic v, logic [1:0] s, logic r, logic f,
                               logic ev, int dk, logic [1:0] ei, logic ee, logic eir);
      vec_t t;
      t.v = v; t.s = s; t.r = r; t.f = f;
      t.ev = ev; t.ed = dword(dk); t.ei = ei; t.ee = ee; t.eir = eir;
      return t;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive4(logic v, logic [1:0] s, logic r, logic f);
      bus4.in_valid  = v;
      bus4.in_sel    = s;
      bus4.out_ready = r;
      bus4.flush     = f;
   endtask

   initial begin
      // Single beat, stream 0..3, back-pressure A/B/C, flush with full stage.
      tbl[0]  = mk(1, 2'd2, 1, 0,  1, 2, 2'd2, 0, 1);
      tbl[1]  = mk(0, 2'd0, 1, 0,  0, 0, 2'd0, 0, 1);
      tbl[2]  = mk(1, 2'd0, 1, 0,  1, 0, 2'd0, 0, 1);
      tbl[3]  = mk(1, 2'd1, 1, 0,  1, 1, 2'd1, 0, 1);
      tbl[4]  = mk(1, 2'd2, 1, 0,  1, 2, 2'd2, 0, 1);
      tbl[5]  = mk(1, 2'd3, 1, 0,  1, 3, 2'd3, 0, 1);
      tbl[6]  = mk(0, 2'd0, 1, 0,  0, 0, 2'd0, 0, 1);
      tbl[7]  = mk(1, 2'd1, 0, 0,  1, 1, 2'd1, 0, 1);
      tbl[8]  = mk(1, 2'd2, 0, 0,  1, 1, 2'd1, 0, 0);
      tbl[9]  = mk(1, 2'd3, 0, 0,  1, 1, 2'd1, 0, 0);
      tbl[10] = mk(1, 2'd3, 1, 0,  1, 2, 2'd2, 0, 1);
      tbl[11] = mk(1, 2'd3, 1, 0,  1, 3, 2'd3, 0, 1);
      tbl[12] = mk(0, 2'd0, 1, 0,  0, 0, 2'd0, 0, 1);
      tbl[13] = mk(1, 2'd0, 0, 0,  1, 0, 2'd0, 0, 1);
      tbl[14] = mk(1, 2'd1, 0, 0,  1, 0, 2'd0, 0, 0);
      tbl[15] = mk(1, 2'd2, 0, 1,  0, 0, 2'd0, 0, 1);
      tbl[16] = mk(0, 2'd0, 1, 0,  0, 0, 2'd0, 0, 1);
      tbl[17] = mk(1, 2'd2, 1, 1,  0, 0, 2'd0, 0, 1);
      tbl[18] = mk(1, 2'd3, 1, 0,  1, 3, 2'd3, 0, 1);
      tbl[19] = mk(0, 2'd0, 1, 0,  0, 0, 2'd0, 0, 1);

      bus4.in_data = {dword(3), dword(2), dword(1), dword(0)};
      bus3.in_data = {dword(12), dword(11), dword(10)};
      drive4(0, 2'd0, 1, 0);
      bus3.in_valid = 0; bus3.in_sel = 2'd0; bus3.out_ready = 1; bus3.flush = 0;

      reset = 1'b1;
      tick();
      chk("rst_valid",    {63'd0, bus4.out_valid},   64'd0);
      chk("rst_data",     bus4.out_data,             64'd0);
      chk("rst_idx",      {62'd0, bus4.out_idx},     64'd0);
      chk("rst_err",      {63'd0, bus4.out_sel_err}, 64'd0);
      chk("rst_in_ready", {63'd0, bus4.in_ready},    64'd1);
      reset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         drive4(tbl[i].v, tbl[i].s, tbl[i].r, tbl[i].f);
         tick();
         chk($sformatf("v%0d_valid", i), {63'd0, bus4.out_valid}, {63'd0, tbl[i].ev});
         chk($sformatf("v%0d_in_ready", i), {63'd0, bus4.in_ready}, {63'd0, tbl[i].eir});
         if (tbl[i].ev) begin
            chk($sformatf("v%0d_data", i), bus4.out_data, tbl[i].ed);
            chk($sformatf("v%0d_idx", i), {62'd0, bus4.out_idx}, {62'd0, tbl[i].ei});
            chk($sformatf("v%0d_err", i), {63'd0, bus4.out_sel_err}, {63'd0, tbl[i].ee});
         end
      end

      // Reset while main and skid both hold beats.
      drive4(1, 2'd1, 0, 0); tick();
      drive4(1, 2'd2, 0, 0); tick();
      chk("pre_rst_in_ready", {63'd0, bus4.in_ready}, 64'd0);
      reset = 1'b1;
      drive4(1, 2'd3, 1, 0);
      tick();
      reset = 1'b0;
      chk("mid_rst_valid",    {63'd0, bus4.out_valid},   64'd0);
      chk("mid_rst_data",     bus4.out_data,             64'd0);
      chk("mid_rst_idx",      {62'd0, bus4.out_idx},     64'd0);
      chk("mid_rst_in_ready", {63'd0, bus4.in_ready},    64'd1);
      drive4(1, 2'd1, 1, 0); tick();
      chk("post_rst_valid", {63'd0, bus4.out_valid}, 64'd1);
      chk("post_rst_data",  bus4.out_data,           dword(1));
      drive4(0, 2'd0, 1, 0); tick();
      chk("post_rst_drain", {63'd0, bus4.out_valid}, 64'd0);

      // NUM_IN=3: out-of-range select yields zero word with error flag.
      bus3.in_valid = 1; bus3.in_sel = 2'd3; tick();
      chk("n3_err_valid", {63'd0, bus3.out_valid},   64'd1);
      chk("n3_err_data",  bus3.out_data,             64'd0);
      chk("n3_err_idx",   {62'd0, bus3.out_idx},     64'd3);
      chk("n3_err_flag",  {63'd0, bus3.out_sel_err}, 64'd1);
      bus3.in_sel = 2'd2; tick();
      chk("n3_ok_data", bus3.out_data,             dword(12));
      chk("n3_ok_idx",  {62'd0, bus3.out_idx},     64'd2);
      chk("n3_ok_flag", {63'd0, bus3.out_sel_err}, 64'd0);
      bus3.in_valid = 0; tick();
      chk("n3_drain", {63'd0, bus3.out_valid}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mux_pipe_stage.md
# mux_pipe_stage

Parametrised, registered N-to-1 operand multiplexer with a valid/ready handshake and a two-entry skid buffer, generalising the datapath 2:1 select to any input count and width. It sits between pipeline stages of the RISC-V core (e.g. forwarding or writeback select) and registers the selected word. It absorbs one cycle of downstream back-pressure without losing data and supports a synchronous flush for branch/exception squash.

## Interface
- WIDTH, 64, data width of each input and the output
- NUM_IN, 4, number of selectable inputs (≥2)
- SEL_W, $clog2(NUM_IN), select width (derived localparam, not overridable)

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
- in_sel  input  SEL_W  binary select index
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat
- flush  input  1  squash all held beats
- out_data  output  WIDTH  registered selected word
- out_idx  output  SEL_W  select index that produced out_data
- out_sel_err  output  1  beat was produced with in_sel ≥ NUM_IN
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat

## Operation
- Storage: main register (drives outputs) and skid register, each holding {data, idx, sel_err, valid}.
- Accept = in_valid & in_ready & !flush. Emit = out_valid & out_ready.
- Select: in_sel < NUM_IN → word in_sel captured, sel_err=0; in_sel ≥ NUM_IN → all-zero word captured, sel_err=1, idx = in_sel unchanged.
- in_ready = !skid_valid (driven from a register; no combinational path from out_ready).
- Main empty or emitting this cycle: skid valid → main loads skid, skid clears; else accepted beat loads main.
- Main full and not emitting: accepted beat loads skid.
- Main loading from skid and accept in the same cycle: accepted beat loads skid (skid stays full) — cannot occur since accept requires skid empty; listed for completeness.
- flush: next cycle main and skid invalid; any beat offered in the flush cycle is dropped; emit in the flush cycle still counts as transferred downstream.
- reset beats flush; flush beats accept.
- Beat order preserved; no beat duplicated or dropped except by flush/reset.

## Timing
- Reset values: out_valid=0, out_data=0, out_idx=0, out_sel_err=0, skid_valid=0, in_ready=1.
- Latency: beat accepted in cycle n appears on outputs in cycle n+1 when main is empty or emitting.
- Throughput: one beat/cycle sustained while out_ready=1.
- Back-pressure: out_ready low with main full → one more beat accepted into skid, in_ready low from next cycle.
- Release: first cycle out_ready=1 emits main; main ← skid next cycle; in_ready returns high that same next cycle.
- out_data/out_idx/out_sel_err stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all held beats discarded; outputs at reset values the cycle after reset sampled high.

## Test plan
- Reset, then NUM_IN=4, WIDTH=64, in_data = {D3,D2,D1,D0} = 0x33..,0x22..,0x11..,0x00..; sel=2, valid one cycle → next cycle out_valid=1, out_data=0x2222222222222222, out_idx=2, out_sel_err=0.
- Streaming sel=0,1,2,3 on consecutive cycles with out_ready=1 → outputs D0,D1,D2,D3 on cycles n+1..n+4, in_ready constantly 1.
- out_ready=0, send beats A,B,C → A in main, B in skid, in_ready=0 from the cycle after B; C held upstream; raise out_ready → A, B, C emitted in order, no loss.
- NUM_IN=3, sel=3 → out_data=0, out_idx=3, out_sel_err=1.
- Main and skid full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, offered beat never appears.
- Reset asserted while main and skid hold beats → next cycle all outputs at reset values; next accepted beat emitted normally after one cycle.
